// File: rtl/if_fetch_buffer.sv
// Elastic IF->ID fetch buffer: DEPTH-entry FIFO of {pc, pc_plus4, instr}.
// Latency: 1 cycle minimum (entry pushed at edge N is visible after edge N, no bypass).
// Backpressure: in_ready_o = (count < DEPTH) from registered state only; full blocks push even on pop.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush_i             synchronous discard of all entries (redirect)
//   in_valid_i/ready_o  upstream handshake; pc_i, pc_plus4_i, instr_i payload
//   out_valid_o/ready_i downstream handshake; pc_o, pc_plus4_o, instr_o head payload
//   count_o             occupancy 0..DEPTH
module if_fetch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic   push;
  logic   pop;
  entry_t head;

  // Explicit wrap so non-power-of-2 depths never address past the last entry.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, so a pop cannot free a slot
  // in the same cycle; this keeps out_ready_i off the upstream ready path.
  assign in_ready_o  = (cnt_q < CNT_FULL);
  assign out_valid_o = (cnt_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (flush_i) begin
      // Redirect: whatever was handshaked this cycle is dropped, the popped
      // head counts as not consumed.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: pc_i, pc_plus4: pc_plus4_i, instr: instr_i};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  // Mask the head when empty so stale storage never leaks downstream.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (!out_valid_o) begin
      head = '0;
    end
  end

  assign pc_o       = head.pc;
  assign pc_plus4_o = head.pc_plus4;
  assign instr_o    = head.instr;
  assign count_o    = cnt_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: DEPTH=2 (dut_a) and DEPTH=3 (dut_b) share stimulus,
// each tracked by a queue-based reference model; directed scenarios then random traffic.
// All comparisons are sampled on the falling edge or between edges.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        out_ready_i;
  logic [31:0] pc_i, pc_plus4_i, instr_i;

  logic        in_ready_a, out_valid_a;
  logic [31:0] pc_a, pc_plus4_a, instr_a;
  logic [1:0]  count_a;
  logic        in_ready_b, out_valid_b;
  logic [31:0] pc_b, pc_plus4_b, instr_b;
  logic [1:0]  count_b;

  int n_total = 0;
  int n_pass  = 0;

  logic [95:0] qa[$];
  logic [95:0] qb[$];

  always #5 clk = ~clk;

  if_fetch_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_a),
    .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .instr_i(instr_i),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_i),
    .pc_o(pc_a), .pc_plus4_o(pc_plus4_a), .instr_o(instr_a),
    .count_o(count_a)
  );

  if_fetch_buffer #(.DATA_WIDTH(32), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_b),
    .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .instr_i(instr_i),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
    .pc_o(pc_b), .pc_plus4_o(pc_plus4_b), .instr_o(instr_b),
    .count_o(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Compare both DUTs against their model queues.
  task automatic compare_all();
    logic [95:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 96'd0;
    hb = (qb.size() != 0) ? qb[0] : 96'd0;
    check("a.out_valid", 32'(out_valid_a), 32'(qa.size() != 0));
    check("a.in_ready",  32'(in_ready_a),  32'(qa.size() < 2));
    check("a.count",     32'(count_a),     32'(qa.size()));
    check("a.pc",        pc_a,             ha[95:64]);
    check("a.pc_plus4",  pc_plus4_a,       ha[63:32]);
    check("a.instr",     instr_a,          ha[31:0]);
    check("b.out_valid", 32'(out_valid_b), 32'(qb.size() != 0));
    check("b.in_ready",  32'(in_ready_b),  32'(qb.size() < 3));
    check("b.count",     32'(count_b),     32'(qb.size()));
    check("b.pc",        pc_b,             hb[95:64]);
    check("b.pc_plus4",  pc_plus4_b,       hb[63:32]);
    check("b.instr",     instr_b,          hb[31:0]);
  endtask

  // Reference behaviour for one clock edge, from the current inputs:
  // ready/valid come from occupancy before the edge; flush drops everything.
  task automatic model_edge();
    logic rdy_a, vld_a, rdy_b, vld_b;
    logic [95:0] w;
    w     = {pc_i, pc_plus4_i, instr_i};
    rdy_a = qa.size() < 2;
    vld_a = qa.size() != 0;
    rdy_b = qb.size() < 3;
    vld_b = qb.size() != 0;
    if (flush_i) begin
      qa.delete();
      qb.delete();
    end else begin
      if (vld_a && out_ready_i) void'(qa.pop_front());
      if (in_valid_i && rdy_a) qa.push_back(w);
      if (vld_b && out_ready_i) void'(qb.pop_front());
      if (in_valid_i && rdy_b) qb.push_back(w);
    end
  endtask

  // Inputs are already driven (after a falling edge); advance one cycle and check.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid_i  = v;
    pc_i        = pc;
    pc_plus4_i  = pc + 32'd4;
    instr_i     = $urandom;
    out_ready_i = rdy;
    flush_i     = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.out_valid", 32'(out_valid_a), 32'd0);
    check("rst.in_ready",  32'(in_ready_a),  32'd1);
    check("rst.count",     32'(count_a),     32'd0);
    check("rst.pc",        pc_a,             32'd0);
    check("rst.count_b",   32'(count_b),     32'd0);

    // Single pass.
    @(negedge clk);
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    instr_i = 32'h13;
    cycle();
    check("single.valid", 32'(out_valid_a), 32'd1);
    check("single.pc",    pc_a,             32'h100);
    check("single.pc4",   pc_plus4_a,       32'h104);
    check("single.instr", instr_a,          32'h13);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle();
    check("single.count", 32'(count_a), 32'd0);

    // Backpressure fill on DEPTH=2; third push refused.
    drive(1'b1, 32'h100, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h104, 1'b0, 1'b0); cycle();
    check("fill.count",    32'(count_a),    32'd2);
    check("fill.in_ready", 32'(in_ready_a), 32'd0);
    check("fill.pc",       pc_a,            32'h100);
    drive(1'b1, 32'h108, 1'b0, 1'b0); cycle();
    check("fill.third_count", 32'(count_a), 32'd2);
    check("fill.third_pc",    pc_a,         32'h100);
    drive(1'b0, 32'd0, 1'b1, 1'b0); cycle();
    check("fill.drain1", pc_a, 32'h104);
    cycle();
    check("fill.drain2", 32'(out_valid_a), 32'd0);
    drain();

    // Streaming with pointer wrap: 10 sequential PCs at one per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      cycle();
      check("stream.b_pc", pc_b, 32'(i * 4));
      check("stream.a_pc", pc_a, 32'(i * 4));
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    cycle();
    check("stream.empty", 32'(out_valid_b), 32'd0);

    // Flush with a concurrent push.
    drive(1'b1, 32'h180, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h184, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h200, 1'b1, 1'b1); cycle();
    check("flush.valid", 32'(out_valid_a), 32'd0);
    check("flush.count", 32'(count_a),     32'd0);
    drive(1'b1, 32'h300, 1'b1, 1'b0); cycle();
    check("flush.next_pc", pc_a, 32'h300);
    drive(1'b0, 32'd0, 1'b1, 1'b0); cycle();
    check("flush.alone", 32'(out_valid_a), 32'd0);
    // Back-to-back flush keeps it empty.
    drive(1'b1, 32'h400, 1'b0, 1'b1); cycle();
    cycle();
    check("flush2.count", 32'(count_a), 32'd0);

    // Asynchronous reset between edges.
    drive(1'b1, 32'h500, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h504, 1'b0, 1'b0); cycle();
    check("arst.pre_count", 32'(count_a), 32'd2);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    check("arst.valid", 32'(out_valid_a), 32'd0);
    check("arst.count", 32'(count_a),     32'd0);
    check("arst.pc",    pc_a,             32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h600, 1'b1, 1'b0); cycle();
    check("arst.new_pc", pc_a, 32'h600);
    drain();

    // Random traffic against the models.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
